// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU with registered single-cycle ops and iterative unsigned MULTU/DIVU into HI/LO.
// Optional: define ALU_OVERFLOW_TRAP_EN to report signed ADD/SUB overflow on the overflow port.
module alu_muldiv_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [5:0]         ALU_control,
   input  logic [WIDTH-1:0]   rs_content,
   input  logic [WIDTH-1:0]   rt_content,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   ALU_result,
   output logic               busy,
   output logic               done,
   output logic               div_zero,
   output logic               overflow
);

   localparam int unsigned CNT_W = SHAMT_W + 1;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [SHAMT_W-1:0] sh_q, sh_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   result_d;
   logic               busy_d, done_d, div_zero_d;

   logic [WIDTH-1:0]   add_res, sub_res, div_diff;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic               div_ge, slt_bit;

   // Datapath shared by the single-cycle ops and one multiply/divide iteration
   always_comb begin
      add_res   = a_q + b_q;
      sub_res   = a_q - b_q;
      slt_bit   = $signed(a_q) < $signed(b_q);
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge    = div_trial >= {1'b0, b_q};
      div_diff  = WIDTH'(div_trial - {1'b0, b_q});
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      sh_d       = sh_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      result_d   = ALU_result;
      busy_d     = busy;
      done_d     = 1'b0;
      div_zero_d = div_zero;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = ALU_control;
               a_d      = rs_content;
               b_d      = rt_content;
               sh_d     = shamt;
               cnt_d    = '0;
               busy_d   = 1'b1;
               acc_hi_d = '0;
               if (ALU_control == F_MULTU) begin
                  state_d  = S_MUL;
                  acc_lo_d = rt_content;
               end else if (ALU_control == F_DIVU && rt_content != '0) begin
                  state_d  = S_DIV;
                  acc_lo_d = rs_content;
               end else begin
                  state_d  = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            div_zero_d = 1'b0;
            case (op_q)
               F_ADD:  result_d = add_res;
               F_SUB:  result_d = sub_res;
               F_AND:  result_d = a_q & b_q;
               F_OR:   result_d = a_q | b_q;
               F_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_bit};
               F_SLL:  result_d = b_q << sh_q;
               F_SRL:  result_d = b_q >> sh_q;
               F_MFHI: result_d = hi_q;
               F_MFLO: result_d = lo_q;
               F_DIVU: begin
                  // Only a zero divisor reaches EXEC as DIVU
                  result_d   = '1;
                  lo_d       = '1;
                  hi_d       = a_q;
                  div_zero_d = 1'b1;
               end
               default: result_d = '0;
            endcase
         end
         S_MUL, S_DIV: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               div_zero_d = 1'b0;
               result_d   = acc_lo_q;
               hi_d       = acc_hi_q;
               lo_d       = acc_lo_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (state_q == S_MUL) begin
                  {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
               end else begin
                  acc_hi_d = div_ge ? div_diff : div_trial[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sh_q       <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         ALU_result <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         div_zero   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sh_q       <= sh_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         ALU_result <= result_d;
         busy       <= busy_d;
         done       <= done_d;
         div_zero   <= div_zero_d;
      end
   end

`ifdef ALU_OVERFLOW_TRAP_EN
   logic ovf_add, ovf_sub, overflow_d;

   // Signed overflow, captured on every completion and held until the next one
   always_comb begin
      ovf_add    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
      ovf_sub    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
      overflow_d = overflow;
      if (done_d) begin
         overflow_d = (op_q == F_ADD && ovf_add) || (op_q == F_SUB && ovf_sub);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) overflow <= 1'b0;
      else     overflow <= overflow_d;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed literal cases plus randomized issue
// checked every cycle against an arithmetic reference model.
module tb_alu_muldiv_unit;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned SHAMT_W = 5;
`ifdef ALU_OVERFLOW_TRAP_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [5:0]         ALU_control;
   logic [WIDTH-1:0]   rs_content, rt_content;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   ALU_result;
   logic               busy, done, div_zero, overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_muldiv_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .ALU_control(ALU_control),
      .rs_content(rs_content), .rt_content(rt_content), .shamt(shamt),
      .ALU_result(ALU_result), .busy(busy), .done(done),
      .div_zero(div_zero), .overflow(overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state plus one pending completion
   logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_ovf = 1'b0;
   int          pend = 0;
   logic [31:0] p_res, p_hi, p_lo;
   logic        p_dz, p_ovf, p_hilo;
   bit          chk_en = 1'b0;

   task automatic predict(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
      longint s;
      logic [63:0] prod;
      p_hilo = 1'b0; p_dz = 1'b0; p_ovf = 1'b0; p_hi = m_hi; p_lo = m_lo; pend = 1;
      case (op)
         F_ADD: begin
            p_res = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            p_ovf = OVF_EN && (s > longint'(2147483647) || s < -longint'(2147483647) - 1);
         end
         F_SUB: begin
            p_res = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            p_ovf = OVF_EN && (s > longint'(2147483647) || s < -longint'(2147483647) - 1);
         end
         F_AND:  p_res = a & b;
         F_OR:   p_res = a | b;
         F_SLT:  p_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         F_SLL:  p_res = b << sh;
         F_SRL:  p_res = b >> sh;
         F_MFHI: p_res = m_hi;
         F_MFLO: p_res = m_lo;
         F_MULTU: begin
            prod = {32'd0, a} * {32'd0, b};
            p_hi = prod[63:32]; p_lo = prod[31:0]; p_res = p_lo; p_hilo = 1'b1;
            pend = WIDTH + 1;
         end
         F_DIVU: begin
            p_hilo = 1'b1;
            if (b == 0) begin
               p_hi = a; p_lo = 32'hFFFF_FFFF; p_res = p_lo; p_dz = 1'b1;
            end else begin
               p_hi = a % b; p_lo = a / b; p_res = p_lo; pend = WIDTH + 1;
            end
         end
         default: p_res = '0;
      endcase
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_hi = '0; m_lo = '0; m_res = '0;
         m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_ovf = 1'b0;
         pend = 0;
         chk_en = 1'b1;
      end else begin
         m_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               m_done = 1'b1; m_busy = 1'b0;
               m_res = p_res; m_dz = p_dz; m_ovf = p_ovf;
               if (p_hilo) begin m_hi = p_hi; m_lo = p_lo; end
            end
         end else if (start) begin
            predict(ALU_control, rs_content, rt_content, shamt);
            m_busy = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",     32'(busy),     32'(m_busy));
         check("done",     32'(done),     32'(m_done));
         check("result",   ALU_result,    m_res);
         check("div_zero", 32'(div_zero), 32'(m_dz));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (busy && done) begin
            errors++;
            $display("FAIL busy_and_done: got both high at %0t", $time);
         end
      end
   end

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      @(negedge clk);
      start = 1'b1; ALU_control = op; rs_content = a; rt_content = b; shamt = sh;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_res);
      int lat;
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
      end else begin
         check({name, "_latency"}, 32'(lat), 32'(exp_lat));
         check({name, "_result"}, ALU_result, exp_res);
      end
   endtask

   logic [5:0] ops [0:10];
   int         ndone;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      ops = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_MFHI, F_MFLO, F_MULTU, F_DIVU};
      rst = 1'b1; start = 1'b0; ALU_control = '0; rs_content = '0; rt_content = '0; shamt = '0;
      repeat (3) @(negedge clk);
      check("rst_result", ALU_result, 32'd0);
      check("rst_busy",   32'(busy),  32'd0);
      check("rst_done",   32'(done),  32'd0);
      rst = 1'b0;

      issue(F_ADD, 32'd15, 32'd12, 5'd0);
      check("add_busy", 32'(busy), 32'd1);
      wait_done("add", 1, 32'd27);
      check("add_busy_at_done", 32'(busy), 32'd0);

      issue(F_MULTU, 32'd7, 32'd6, 5'd0);     wait_done("mul7x6", WIDTH + 1, 32'd42);
      issue(F_MFLO, 32'd0, 32'd0, 5'd0);      wait_done("mflo42", 1, 32'd42);
      issue(F_MFHI, 32'd0, 32'd0, 5'd0);      wait_done("mfhi0", 1, 32'd0);
      issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0); wait_done("mulmax", WIDTH + 1, 32'd1);
      issue(F_MFHI, 32'd0, 32'd0, 5'd0);      wait_done("mfhi_max", 1, 32'hFFFF_FFFE);
      issue(F_DIVU, 32'd100, 32'd7, 5'd0);    wait_done("div100_7", WIDTH + 1, 32'd14);
      issue(F_MFHI, 32'd0, 32'd0, 5'd0);      wait_done("mfhi_rem", 1, 32'd2);
      issue(F_DIVU, 32'd5, 32'd0, 5'd0);      wait_done("div_by0", 1, 32'hFFFF_FFFF);
      check("div_by0_flag", 32'(div_zero), 32'd1);
      issue(F_MFHI, 32'd0, 32'd0, 5'd0);      wait_done("mfhi_div0", 1, 32'd5);
      check("div_zero_clear", 32'(div_zero), 32'd0);
      issue(F_SUB, 32'd5, 32'd7, 5'd0);       wait_done("sub", 1, 32'hFFFF_FFFE);
      issue(F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0); wait_done("slt", 1, 32'd1);
      issue(F_SRL, 32'd0, 32'h8000_0000, 5'd31); wait_done("srl", 1, 32'd1);
      issue(F_SLL, 32'd0, 32'd1, 5'd4);       wait_done("sll", 1, 32'd16);
      issue(6'b111111, 32'd9, 32'd9, 5'd0);   wait_done("unknown", 1, 32'd0);

      // start while busy must be ignored
      issue(F_MULTU, 32'd3, 32'd5, 5'd0);
      repeat (4) @(negedge clk);
      start = 1'b1; ALU_control = F_ADD; rs_content = 32'd1; rt_content = 32'd1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("ignored_start_dones", 32'(ndone), 32'd1);
      issue(F_MFLO, 32'd0, 32'd0, 5'd0);      wait_done("mflo15", 1, 32'd15);

      // reset in the middle of a multiply
      issue(F_MULTU, 32'd9, 32'd9, 5'd0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      issue(F_MFLO, 32'd0, 32'd0, 5'd0);      wait_done("abort_lo", 1, 32'd0);
      issue(F_MFHI, 32'd0, 32'd0, 5'd0);      wait_done("abort_hi", 1, 32'd0);
      issue(F_ADD, 32'd1, 32'd35, 5'd0);      wait_done("add_after_rst", 1, 32'd36);

      issue(F_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0); wait_done("add_ovf", 1, 32'h8000_0000);
      check("ovf_flag", 32'(overflow), 32'(OVF_EN));
      issue(F_ADD, 32'd2, 32'd3, 5'd0);       wait_done("add_noovf", 1, 32'd5);
      check("ovf_clear", 32'(overflow), 32'd0);

      // randomized issue, including starts while busy and rare resets
      for (int i = 0; i < 1500; i++) begin
         int k;
         @(negedge clk);
         k = int'($urandom_range(0, 11));
         rst = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 2) == 0);
         ALU_control = (k == 11) ? 6'($urandom) : ops[k];
         rs_content = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         rt_content = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         shamt = 5'($urandom);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
